// File: rtl/human_move_ctrl.sv
// Key-driven movement controller: samples synchronised direction keys on a periodic tick,
// issues a one-cycle move request and waits for the sprite stage to finish or time out.
module human_move_ctrl #(
  parameter int unsigned TICK_CYCLES    = 833333,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic clk,
  input  logic resetn,
  input  logic key_up,
  input  logic key_down,
  input  logic key_left,
  input  logic key_right,
  input  logic finish_P,
  output logic EN,
  output logic up,
  output logic down,
  output logic left,
  output logic right,
  output logic busy,
  output logic overrun,
  output logic timeout_err
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE} state_t;

  localparam logic [19:0] TICK_LAST    = 20'(TICK_CYCLES - 1);
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state_reg, state_next;
  logic [3:0]  key_meta_reg, key_sync_reg;
  logic [19:0] tick_cnt_reg, tick_cnt_next;
  logic [15:0] to_cnt_reg, to_cnt_next;
  logic [3:0]  dir_reg, dir_next;
  logic        pending_reg, pending_next;
  logic        overrun_reg, overrun_next;
  logic        timeout_reg, timeout_next;
  logic [3:0]  dir_resolved;
  logic        key_any;
  logic        tick;

  // Bit order everywhere is {up, down, left, right}
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      key_meta_reg <= 4'b0000;
      key_sync_reg <= 4'b0000;
    end else begin
      key_meta_reg <= {key_up, key_down, key_left, key_right};
      key_sync_reg <= key_meta_reg;
    end
  end

  assign tick          = (tick_cnt_reg == TICK_LAST);
  assign tick_cnt_next = tick ? 20'd0 : tick_cnt_reg + 20'd1;
  assign key_any       = |key_sync_reg;

  // Priority up > down > left > right, so opposing keys never yield two bits
  always_comb begin
    dir_resolved = 4'b0000;
    if (key_sync_reg[3])      dir_resolved = 4'b1000;
    else if (key_sync_reg[2]) dir_resolved = 4'b0100;
    else if (key_sync_reg[1]) dir_resolved = 4'b0010;
    else if (key_sync_reg[0]) dir_resolved = 4'b0001;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg    <= IDLE;
      tick_cnt_reg <= 20'd0;
      to_cnt_reg   <= 16'd0;
      dir_reg      <= 4'b0000;
      pending_reg  <= 1'b0;
      overrun_reg  <= 1'b0;
      timeout_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      tick_cnt_reg <= tick_cnt_next;
      to_cnt_reg   <= to_cnt_next;
      dir_reg      <= dir_next;
      pending_reg  <= pending_next;
      overrun_reg  <= overrun_next;
      timeout_reg  <= timeout_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    to_cnt_next  = to_cnt_reg;
    dir_next     = dir_reg;
    pending_next = pending_reg;
    overrun_next = overrun_reg;
    timeout_next = timeout_reg;

    // A tick arriving while a move is in flight is remembered once; a second one is lost
    if (tick && state_reg != IDLE) begin
      pending_next = 1'b1;
      if (pending_reg) overrun_next = 1'b1;
    end

    case (state_reg)
      IDLE: begin
        dir_next = 4'b0000;
        if (tick || pending_reg) begin
          pending_next = 1'b0;
          if (key_any) begin
            state_next = ISSUE;
            dir_next   = dir_resolved;
          end
        end
      end
      ISSUE: begin
        state_next  = WAIT_DONE;
        to_cnt_next = 16'd0;
      end
      WAIT_DONE: begin
        if (to_cnt_reg != 16'hFFFF) to_cnt_next = to_cnt_reg + 16'd1;
        if (finish_P) begin
          state_next = IDLE;
        end else if (to_cnt_reg >= TIMEOUT_LAST) begin
          timeout_next = 1'b1;
          state_next   = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign EN          = (state_reg == ISSUE);
  assign busy        = (state_reg != IDLE);
  assign {up, down, left, right} = dir_reg;
  assign overrun     = overrun_reg;
  assign timeout_err = timeout_reg;

endmodule

// File: tb/tb_human_move_ctrl.sv
// Directed bench for human_move_ctrl: expected move requests are queued per scenario and
// matched against observed EN pulses, with hold/idle/busy-length checks on every cycle.
module tb_human_move_ctrl;

  logic clk = 1'b0;
  logic resetn;
  logic key_up, key_down, key_left, key_right;
  logic finish_P;

  logic en16, up16, down16, left16, right16, busy16, ovr16, to16;
  logic en64, up64, down64, left64, right64, busy64, ovr64, to64;

  human_move_ctrl #(.TICK_CYCLES(10), .TIMEOUT_CYCLES(16)) dut16 (
    .clk(clk), .resetn(resetn),
    .key_up(key_up), .key_down(key_down), .key_left(key_left), .key_right(key_right),
    .finish_P(finish_P), .EN(en16),
    .up(up16), .down(down16), .left(left16), .right(right16),
    .busy(busy16), .overrun(ovr16), .timeout_err(to16)
  );

  human_move_ctrl #(.TICK_CYCLES(10), .TIMEOUT_CYCLES(64)) dut64 (
    .clk(clk), .resetn(resetn),
    .key_up(key_up), .key_down(key_down), .key_left(key_left), .key_right(key_right),
    .finish_P(finish_P), .EN(en64),
    .up(up64), .down(down64), .left(left64), .right(right64),
    .busy(busy64), .overrun(ovr64), .timeout_err(to64)
  );

  always #5 clk = ~clk;

  // Observed instance: 0 -> TIMEOUT 16, 1 -> TIMEOUT 64
  bit         sel;
  logic       m_en, m_busy, m_ovr, m_to;
  logic [3:0] m_dir;
  assign m_en   = sel ? en64 : en16;
  assign m_busy = sel ? busy64 : busy16;
  assign m_ovr  = sel ? ovr64 : ovr16;
  assign m_to   = sel ? to64 : to16;
  assign m_dir  = sel ? {up64, down64, left64, right64} : {up16, down16, left16, right16};

  int cyc;
  always @(posedge clk or negedge resetn) begin
    if (!resetn) cyc <= 0;
    else         cyc <= cyc + 1;
  end

  typedef struct {
    int         cyc;
    logic [3:0] dir;
    int         len;
  } exp_t;
  exp_t exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  int fin_delay = -1;
  int stray_at  = -1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s at cyc %0d: observed %0h expected %0h", tag, cyc, obs, exp);
  endtask

  task automatic push(input int c, input logic [3:0] d, input int l);
    exp_t e;
    e.cyc = c;
    e.dir = d;
    e.len = l;
    exp_q.push_back(e);
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic start(input bit s, input logic [3:0] k, input int d);
    #3;
    resetn = 1'b0;
    {key_up, key_down, key_left, key_right} = k;
    sel       = s;
    fin_delay = d;
    stray_at  = -1;
    repeat (3) @(negedge clk);
    chk("rst_outs", {m_en, m_busy, m_dir, m_ovr, m_to}, 0);
    exp_q.delete();
  endtask

  task automatic release_rst();
    #3;
    resetn = 1'b1;
  endtask

  // Monitor and sprite-stage responder, sampled on the falling edge
  initial begin
    exp_t       e;
    bit         prev_busy = 1'b0;
    int         run = 0;
    int         cur_len = 0;
    int         finish_at = -1;
    logic [3:0] cur_dir = 4'b0000;
    finish_P = 1'b0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        prev_busy = 1'b0;
        cur_len   = 0;
        finish_at = -1;
        finish_P  = 1'b0;
      end else begin
        if (m_en) begin
          chk("en_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("en_cycle", cyc, e.cyc);
            chk("en_dir", m_dir, e.dir);
            cur_dir = e.dir;
            cur_len = e.len;
            run     = 0;
            finish_at = (fin_delay >= 0) ? cyc + fin_delay : -1;
          end
          $display("move cyc=%0d dir(udlr)=%b", cyc, m_dir);
        end
        if (m_busy) begin
          run++;
          chk("dir_hold", m_dir, cur_dir);
        end else begin
          chk("en_idle", m_en, 0);
          if (prev_busy && cur_len != 0) chk("busy_len", run, cur_len);
          if (!prev_busy) chk("dir_idle", m_dir, 0);
        end
        prev_busy = m_busy;
        finish_P  = (cyc == finish_at) || (cyc == stray_at);
      end
    end
  end

  initial begin
    resetn = 1'b0;
    sel    = 1'b0;
    {key_up, key_down, key_left, key_right} = 4'b0000;

    // Held right key, finish 5 cycles after each request
    start(1'b0, 4'b0001, 5);
    push(10, 4'b0001, 6); push(20, 4'b0001, 6); push(30, 4'b0001, 6); push(40, 4'b0001, 6);
    release_rst();
    wait_cyc(47);
    chk("a_overrun", m_ovr, 0);
    chk("a_drain", exp_q.size(), 0);

    // Opposing up+down resolves to up
    start(1'b0, 4'b1100, 5);
    push(10, 4'b1000, 6); push(20, 4'b1000, 6); push(30, 4'b1000, 6);
    release_rst();
    wait_cyc(37);
    chk("b_drain", exp_q.size(), 0);

    // finish_P coincides with tick; key change mid-move must not disturb latched direction
    start(1'b0, 4'b0100, 9);
    push(10, 4'b0100, 10); push(21, 4'b1000, 10); push(32, 4'b1000, 10); push(43, 4'b1000, 10);
    release_rst();
    wait_cyc(13);
    key_up = 1'b1;
    wait_cyc(50);
    chk("g_overrun", m_ovr, 0);
    chk("g_drain", exp_q.size(), 0);

    // finish_P only during ISSUE (ignored) -> timeouts
    start(1'b0, 4'b0010, 0);
    push(10, 4'b0010, 17); push(28, 4'b0010, 17); push(46, 4'b0010, 17);
    release_rst();
    wait_cyc(26);
    chk("c_to_before", m_to, 0);
    wait_cyc(27);
    chk("c_to_set", m_to, 1);
    wait_cyc(50);
    chk("c_to_sticky", m_to, 1);
    chk("c_drain", exp_q.size(), 0);

    // Slow completion with long timeout -> pending plus overrun
    start(1'b1, 4'b0010, 25);
    push(10, 4'b0010, 26); push(37, 4'b0010, 26); push(64, 4'b0010, 26);
    release_rst();
    wait_cyc(25);
    chk("d_ovr_before", m_ovr, 0);
    wait_cyc(35);
    chk("d_ovr_set", m_ovr, 1);
    wait_cyc(68);
    chk("d_ovr_sticky", m_ovr, 1);
    chk("d_no_timeout", m_to, 0);
    chk("d_drain", exp_q.size(), 0);

    // Reset mid-move: outputs clear at once, next request needs a fresh tick
    start(1'b0, 4'b0001, 5);
    push(10, 4'b0001, 0);
    release_rst();
    wait_cyc(12);
    #2;
    resetn = 1'b0;
    #1;
    chk("e_async_rst", {m_en, m_busy, m_dir, m_ovr, m_to}, 0);
    chk("e_drain1", exp_q.size(), 0);
    start(1'b0, 4'b0001, 5);
    push(10, 4'b0001, 6); push(20, 4'b0001, 6);
    release_rst();
    wait_cyc(27);
    chk("e_drain2", exp_q.size(), 0);

    // No keys: ticks are discarded, stray finish_P in IDLE ignored
    start(1'b0, 4'b0000, 5);
    release_rst();
    stray_at = 30;
    wait_cyc(50);
    chk("f_busy", m_busy, 0);
    key_down = 1'b1;
    push(60, 4'b0100, 6);
    wait_cyc(67);
    chk("f_overrun", m_ovr, 0);
    chk("f_drain", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
